// File: rtl/lcd_host_seq_if.sv
// Host <-> environment signal bundle for lcd_host_seq: upstream request queue,
// image RAM port, LCD controller handshake and captured-window outputs.
interface lcd_host_seq_if;
   logic       req_valid;
   logic [3:0] req_cmd;
   logic       req_ready;
   logic       img_rd;
   logic [6:0] img_addr;
   logic [7:0] img_data;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       busy;
   logic [7:0] dataout;
   logic       output_valid;
   logic       win_valid;
   logic [7:0] win_data;
   logic [3:0] win_idx;
   logic       frame_done;
   logic       frame_err;

   modport master (
      input  req_valid, req_cmd, img_data, busy, dataout, output_valid,
      output req_ready, img_rd, img_addr, cmd, cmd_valid, datain,
             win_valid, win_data, win_idx, frame_done, frame_err
   );

   modport slave (
      output req_valid, req_cmd, img_data, busy, dataout, output_valid,
      input  req_ready, img_rd, img_addr, cmd, cmd_valid, datain,
             win_valid, win_data, win_idx, frame_done, frame_err
   );
endinterface

// File: rtl/lcd_host_seq.sv
// Host command sequencer for the LCD controller: issues commands, streams the LOAD
// image from RAM and captures the returned window. Optional watchdog: LCD_HOST_TIMEOUT_EN.
module lcd_host_seq #(
   parameter int IMG_PIX = 108,
   parameter int WIN_PIX = 16,
   parameter int TIMEOUT = 255
) (
   input logic            clk,
   input logic            reset,
   lcd_host_seq_if.master bus
);

   typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT_HI, COLLECT, DONE} state_t;
   localparam logic [3:0] CMD_LOAD = 4'd0;

   state_t     state;
   logic [6:0] pix_cnt;
   logic [4:0] win_cnt;
   logic       accept;
   logic       capture;
   logic       wd_hit;

   if (IMG_PIX < 2 || IMG_PIX > 128 || WIN_PIX < 1 || WIN_PIX > 31 ||
       TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("lcd_host_seq: parameter out of range");
   end

   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   function automatic logic [4:0] cnt_after(input logic [4:0] v, input logic hit);
      return hit ? sat_inc(v) : v;
   endfunction

   assign bus.datain = bus.img_data;
   assign accept     = (state == ISSUE) && bus.cmd_valid && !bus.busy;
   assign capture    = ((state == WAIT_HI) || (state == COLLECT)) && bus.output_valid;

`ifdef LCD_HOST_TIMEOUT_EN
   logic [7:0] wdog;
   logic       watched;
   logic       wd_reload;

   assign watched = (state == ISSUE) || (state == WAIT_HI) || (state == COLLECT);
   // Entering ISSUE always comes from an unwatched state, so only the two watched->watched edges need a reload
   assign wd_reload = !watched || bus.output_valid || accept || ((state == WAIT_HI) && bus.busy);
   assign wd_hit    = !wd_reload && (wdog == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         wdog <= 8'd0;
      else if (wd_reload) wdog <= 8'd0;
      else                wdog <= wdog + 8'd1;
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         pix_cnt        <= 7'd0;
         win_cnt        <= 5'd0;
         bus.req_ready  <= 1'b0;
         bus.cmd        <= 4'd0;
         bus.cmd_valid  <= 1'b0;
         bus.img_rd     <= 1'b0;
         bus.img_addr   <= 7'd0;
         bus.win_valid  <= 1'b0;
         bus.win_data   <= 8'd0;
         bus.win_idx    <= 4'd0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;
      end else begin
         bus.win_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.frame_err  <= 1'b0;

         if (capture) begin
            bus.win_valid <= 1'b1;
            bus.win_data  <= bus.dataout;
            bus.win_idx   <= win_cnt[3:0];
            win_cnt       <= sat_inc(win_cnt);
         end

         case (state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  state         <= ISSUE;
                  bus.req_ready <= 1'b0;
                  bus.cmd       <= bus.req_cmd;
                  bus.cmd_valid <= 1'b1;
                  if (bus.req_cmd == CMD_LOAD) begin
                     bus.img_rd   <= 1'b1;
                     bus.img_addr <= 7'd0;
                  end
               end
            end
            ISSUE: begin
               if (accept) begin
                  bus.cmd_valid <= 1'b0;
                  pix_cnt       <= 7'd0;
                  state         <= (bus.cmd == CMD_LOAD) ? LOAD : WAIT_HI;
               end else if (wd_hit) begin
                  bus.cmd_valid  <= 1'b0;
                  bus.img_rd     <= 1'b0;
                  bus.img_addr   <= 7'd0;
                  bus.frame_done <= 1'b1;
                  bus.frame_err  <= 1'b1;
                  state          <= DONE;
               end
            end
            // Controller raises busy late during LOAD, so the stream is purely count-driven
            LOAD: begin
               if (pix_cnt == 7'(IMG_PIX - 1)) state <= WAIT_HI;
               else                            pix_cnt <= pix_cnt + 7'd1;
            end
            WAIT_HI: begin
               if (bus.busy) begin
                  state <= COLLECT;
               end else if (wd_hit) begin
                  bus.frame_done <= 1'b1;
                  bus.frame_err  <= 1'b1;
                  state          <= DONE;
               end
            end
            COLLECT: begin
               if (!bus.busy) begin
                  bus.frame_done <= 1'b1;
                  bus.frame_err  <= (cnt_after(win_cnt, bus.output_valid) != 5'(WIN_PIX));
                  state          <= DONE;
               end else if (wd_hit) begin
                  bus.frame_done <= 1'b1;
                  bus.frame_err  <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               win_cnt       <= 5'd0;
               bus.req_ready <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Address k is presented in the cycle before edge E(k); E0 is the accept edge
         if (bus.img_rd && ((state == LOAD) || accept)) begin
            if (bus.img_addr == 7'(IMG_PIX - 1)) begin
               bus.img_rd   <= 1'b0;
               bus.img_addr <= 7'd0;
            end else begin
               bus.img_addr <= bus.img_addr + 7'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_host_seq.sv
// Self-checking bench for lcd_host_seq: directed vector table, randomized transactions
// against a transaction-level model, reset and watchdog corner sequences.
module tb_lcd_host_seq;
   localparam int IMG = 108;
   localparam int WIN = 16;

   typedef struct {
      logic [3:0] cmd;
      int         stall;
      int         nwin;
      int         gap;
      int         late;
      bit         same;
      bit         seqv;
      bit         exp_err;
   } vec_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] ram [0:127];
   int         n_checks = 0;
   int         n_fail   = 0;
   vec_t       tbl [6];

   lcd_host_seq_if bus ();

   lcd_host_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous image RAM: data one cycle after the read strobe
   always @(posedge clk) if (bus.img_rd) bus.img_data <= ram[bus.img_addr];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "bench time limit expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One full command transaction as the controller model sees it. Starts and ends on a negedge.
   task automatic run_txn(input logic [3:0] c, input int stall, input int nwin, input int gap,
                          input int late, input bit same, input bit seqv, input bit exp_err);
      int         t;
      logic [7:0] v;
      t = 0;
      while (bus.req_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("req_ready_idle", int'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_cmd   = c;
      bus.busy      = (stall > 0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_cmd   = 4'($urandom);
      chk("cmd_valid_rise", int'(bus.cmd_valid), 1);
      chk("cmd_value", int'(bus.cmd), int'(c));
      chk("req_ready_low", int'(bus.req_ready), 0);
      chk("img_rd_issue", int'(bus.img_rd), (c == 4'd0) ? 1 : 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("cmd_valid_hold", int'(bus.cmd_valid), 1);
         chk("cmd_hold", int'(bus.cmd), int'(c));
      end
      bus.busy = 1'b0;
      @(negedge clk);
      chk("cmd_valid_clear", int'(bus.cmd_valid), 0);
      if (c == 4'd0) begin
         for (int k = 0; k < IMG; k++) begin
            if (k > 0) @(negedge clk);
            chk("load_pixel", int'(bus.datain), int'(ram[k]));
            chk("load_rd", int'(bus.img_rd), (k < IMG - 1) ? 1 : 0);
            if (k < IMG - 1) chk("load_addr", int'(bus.img_addr), k + 1);
            if (k == late) bus.busy = 1'b1;
         end
         @(negedge clk);
         chk("img_rd_off", int'(bus.img_rd), 0);
      end
      if (!same || nwin == 0) begin
         bus.busy = 1'b1;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("win_idle", int'(bus.win_valid), 0);
         end
      end
      for (int i = 0; i < nwin; i++) begin
         v = seqv ? 8'(13 + 3 * i) : 8'($urandom);
         bus.output_valid = 1'b1;
         bus.dataout      = v;
         bus.busy         = 1'b1;
         @(negedge clk);
         bus.output_valid = 1'b0;
         chk("win_valid", int'(bus.win_valid), 1);
         chk("win_data", int'(bus.win_data), int'(v));
         chk("win_idx", int'(bus.win_idx), i % WIN);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            chk("win_gap", int'(bus.win_valid), 0);
         end
      end
      @(negedge clk);
      chk("win_valid_idle", int'(bus.win_valid), 0);
      chk("done_not_early", int'(bus.frame_done), 0);
      bus.busy = 1'b0;
      @(negedge clk);
      chk("frame_done", int'(bus.frame_done), 1);
      chk("frame_err", int'(bus.frame_err), int'(exp_err));
      @(negedge clk);
      chk("frame_done_pulse", int'(bus.frame_done), 0);
      chk("req_ready_after", int'(bus.req_ready), 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
      chk({tag, "_cmd_valid"}, int'(bus.cmd_valid), 0);
      chk({tag, "_cmd"}, int'(bus.cmd), 0);
      chk({tag, "_img_rd"}, int'(bus.img_rd), 0);
      chk({tag, "_img_addr"}, int'(bus.img_addr), 0);
      chk({tag, "_win_valid"}, int'(bus.win_valid), 0);
      chk({tag, "_win_data"}, int'(bus.win_data), 0);
      chk({tag, "_win_idx"}, int'(bus.win_idx), 0);
      chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
      chk({tag, "_frame_err"}, int'(bus.frame_err), 0);
   endtask

   initial begin
      int t;
      int seen;
      bus.req_valid    = 1'b0;
      bus.req_cmd      = 4'd0;
      bus.busy         = 1'b0;
      bus.dataout      = 8'd0;
      bus.output_valid = 1'b0;
      for (int k = 0; k < 128; k++) ram[k] = 8'(k);

      // cmd, stall, nwin, gap, late busy pixel, same-cycle, sequential data, expected err
      tbl[0] = '{4'd0,  0, 16, 2, 100, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{4'd3,  5, 16, 1, IMG, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{4'd4,  0, 15, 1, IMG, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{4'd12, 1, 16, 0, IMG, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{4'd7,  0, 17, 3, IMG, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{4'd8,  2,  0, 1, IMG, 1'b0, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      #1;
      chk("req_ready_at_release", int'(bus.req_ready), 0);
      @(negedge clk);
      chk("req_ready_first_clk", int'(bus.req_ready), 1);

      for (int i = 0; i < 6; i++)
         run_txn(tbl[i].cmd, tbl[i].stall, tbl[i].nwin, tbl[i].gap, tbl[i].late,
                 tbl[i].same, tbl[i].seqv, tbl[i].exp_err);

      for (int r = 0; r < 20; r++) begin
         logic [3:0] c;
         int         nw;
         bit         sm;
         c  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         if (c == 4'd0) for (int k = 0; k < IMG; k++) ram[k] = 8'($urandom);
         nw = $urandom_range(13, 19);
         sm = ($urandom_range(0, 3) == 0);
         run_txn(c, $urandom_range(0, 4), nw, sm ? 0 : $urandom_range(0, 3),
                 (c == 4'd0) ? $urandom_range(IMG - 20, IMG) : IMG, sm, 1'b0, nw != WIN);
      end

      // Reset in the middle of a LOAD stream
      for (int k = 0; k < IMG; k++) ram[k] = 8'(k);
      bus.req_valid = 1'b1;
      bus.req_cmd   = 4'd0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      repeat (50) @(negedge clk);
      chk("mid_load_pixel", int'(bus.datain), 50);
      chk("mid_load_addr", int'(bus.img_addr), 51);
      reset = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", int'(bus.req_ready), 1);
      run_txn(4'd0, 0, 16, 1, IMG, 1'b0, 1'b1, 1'b0);

      // Controller never raises busy after command 5
      bus.req_valid = 1'b1;
      bus.req_cmd   = 4'd5;
      bus.busy      = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("to_cmd_accepted", int'(bus.cmd_valid), 0);
`ifdef LCD_HOST_TIMEOUT_EN
      t = 0;
      while (bus.frame_done !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("timeout_done", int'(bus.frame_done), 1);
      chk("timeout_err", int'(bus.frame_err), 1);
      chk("timeout_window", (t >= 250 && t <= 260) ? 1 : 0, 1);
      @(negedge clk);
      chk("timeout_ready", int'(bus.req_ready), 1);
`else
      seen = 0;
      t    = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.frame_done) seen = 1;
         t++;
      end
      chk("no_watchdog_done", seen, 0);
      chk("stuck_wait_hi_ready", int'(bus.req_ready), 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("recover_ready", int'(bus.req_ready), 1);
`endif
      run_txn(4'd6, 1, 16, 1, IMG, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
